activation_sequencer: RTL

ACTIVATION_SEQUENCER -- requirements
Module: activation_sequencer

---
 rtl/activation_sequencer.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/activation_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : activation_sequencer
// Brief   : Feeds per-neuron x/theta operand pairs to a shared Activation unit
//           and collects one result per neuron into a readable result file.
// Revision: 1.0 - initial release
// ============================================================================
module activation_sequencer #(
  parameter int N_TERMS     = 3,
  parameter int MAX_NEURONS = 4,
  parameter int TIMEOUT     = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        start,
  input  logic [2:0]  num_neurons,
  input  logic [1:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] act_x,
  output logic [31:0] act_theta,
  output logic        act_x_stb,
  output logic        act_theta_stb,
  input  logic        act_next,
  input  logic [31:0] act_result,
  input  logic        act_result_stb,
  output logic        act_result_ack
);

  localparam int         c_WD_W    = $clog2(TIMEOUT + 1);
  localparam int         c_N_THETA = MAX_NEURONS * N_TERMS;
  localparam logic [2:0] c_MAX_NUM = 3'(MAX_NEURONS);
  localparam logic [1:0] c_K_LAST  = 2'(N_TERMS - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FEED     = 3'd1,
    S_WAIT_RES = 3'd2,
    S_ACK      = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_n, w_n_nxt, r_k, w_k_nxt;
  logic [1:0]        w_n_inc, w_k_inc;
  logic [2:0]        r_num, w_num_nxt;
  logic [c_WD_W-1:0] r_wd, w_wd_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic              r_stb, w_stb_nxt;
  logic              r_ack, w_ack_nxt;
  logic [31:0]       r_act_x, w_x_nxt;
  logic [31:0]       r_act_theta, w_theta_nxt;
  logic              w_res_we;
  logic              w_timeout;

  logic [31:0] r_x     [N_TERMS];
  logic [31:0] r_theta [c_N_THETA];
  logic [31:0] r_res   [MAX_NEURONS];

  // theta[n][k] lives at flat index 3n+k (host address minus 4)
  function automatic logic [3:0] theta_idx(input logic [1:0] n, input logic [1:0] k);
    return ({2'b00, n} * 4'd3) + {2'b00, k};
  endfunction

  assign w_n_inc   = r_n + 2'd1;
  assign w_k_inc   = r_k + 2'd1;
  assign w_timeout = ((r_state == S_FEED) || (r_state == S_WAIT_RES)) &&
                     (r_wd == c_WD_W'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_n_nxt     = r_n;
    w_k_nxt     = r_k;
    w_num_nxt   = r_num;
    w_wd_nxt    = r_wd;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_stb_nxt   = r_stb;
    w_ack_nxt   = 1'b0;
    w_x_nxt     = r_act_x;
    w_theta_nxt = r_act_theta;
    w_res_we    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((num_neurons != 3'd0) && (num_neurons <= c_MAX_NUM)) begin
            w_state_nxt = S_FEED;
            w_n_nxt     = 2'd0;
            w_k_nxt     = 2'd0;
            w_wd_nxt    = '0;
            w_num_nxt   = num_neurons;
            w_busy_nxt  = 1'b1;
            w_stb_nxt   = 1'b1;
            w_x_nxt     = r_x[0];
            w_theta_nxt = r_theta[0];
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      // A result strobe arriving here is a stray one and is never captured
      S_FEED: begin
        w_wd_nxt = r_wd + c_WD_W'(1);
        if (act_next) begin
          if (r_k == c_K_LAST) begin
            w_stb_nxt   = 1'b0;
            w_state_nxt = S_WAIT_RES;
          end else begin
            w_k_nxt     = w_k_inc;
            w_x_nxt     = r_x[w_k_inc];
            w_theta_nxt = r_theta[theta_idx(r_n, w_k_inc)];
          end
        end
      end

      S_WAIT_RES: begin
        w_wd_nxt = r_wd + c_WD_W'(1);
        if (act_result_stb) begin
          w_res_we    = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = S_ACK;
        end
      end

      S_ACK: begin
        if ({1'b0, r_n} == (r_num - 3'd1)) begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_n_nxt     = w_n_inc;
          w_k_nxt     = 2'd0;
          w_wd_nxt    = '0;
          w_stb_nxt   = 1'b1;
          w_x_nxt     = r_x[0];
          w_theta_nxt = r_theta[theta_idx(w_n_inc, 2'd0)];
          w_state_nxt = S_FEED;
        end
      end

      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_busy_nxt  = 1'b0;
        w_stb_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // Watchdog abort wins over anything the unit is doing this cycle
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_stb_nxt   = 1'b0;
      w_ack_nxt   = 1'b0;
      w_busy_nxt  = 1'b0;
      w_err_nxt   = 1'b1;
      w_res_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_n         <= 2'd0;
      r_k         <= 2'd0;
      r_num       <= 3'd0;
      r_wd        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_stb       <= 1'b0;
      r_ack       <= 1'b0;
      r_act_x     <= '0;
      r_act_theta <= '0;
      for (int i = 0; i < N_TERMS; i++)     r_x[i]     <= '0;
      for (int i = 0; i < c_N_THETA; i++)   r_theta[i] <= '0;
      for (int i = 0; i < MAX_NEURONS; i++) r_res[i]   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_n         <= w_n_nxt;
      r_k         <= w_k_nxt;
      r_num       <= w_num_nxt;
      r_wd        <= w_wd_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_stb       <= w_stb_nxt;
      r_ack       <= w_ack_nxt;
      r_act_x     <= w_x_nxt;
      r_act_theta <= w_theta_nxt;
      // Operand file is frozen while a run is using it
      if (wr_en && !r_busy) begin
        if (wr_addr < 4'd3)
          r_x[wr_addr[1:0]] <= wr_data;
        else if (wr_addr >= 4'd4)
          r_theta[wr_addr - 4'd4] <= wr_data;
      end
      if (w_res_we)
        r_res[r_n] <= act_result;
    end
  end

  assign rd_data        = r_res[rd_addr];
  assign busy           = r_busy;
  assign done           = r_done;
  assign err            = r_err;
  assign act_x          = r_act_x;
  assign act_theta      = r_act_theta;
  assign act_x_stb      = r_stb;
  assign act_theta_stb  = r_stb;
  assign act_result_ack = r_ack;

endmodule
`default_nettype wire
